counter_ctrl: RTL
=================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, counter width; only 4 is supported (matches up_down_counter).
REQ-002 Ports: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Ports: rst  input  1  reset, synchronous, active-high.
REQ-004 Ports: cmd_valid  input  1  command offered.
REQ-005 Ports: cmd_ready  output  1  controller can accept a command.
REQ-006 Ports: cmd_op  input  2  opcode: 00 LOAD, 01 UP, 10 DOWN, 11 PAUSE.
REQ-007 Ports: cmd_arg  input  WIDTH  LOAD value, or step/cycle count for UP/DOWN/PAUSE.
REQ-008 Ports: abort  input  1  terminate the executing command.
REQ-009 Ports: count  output  WIDTH  counter value.
REQ-010 Ports: busy  output  1  command executing.
REQ-011 Ports: done  output  1  one-cycle pulse on normal command completion.
REQ-012 Ports: wrap  output  1  one-cycle pulse when count wraps (15->0 on UP, 0->15 on DOWN).

Function
REQ-013 Handshake: a command SHALL be accepted on a rising edge where cmd_valid && cmd_ready; cmd_op and cmd_arg are captured at that edge.
REQ-014 cmd_ready SHALL be 1 only in state IDLE and SHALL be 0 while rst is high.
REQ-015 The FSM SHALL have states IDLE and EXEC; acceptance moves IDLE->EXEC and loads remain=cmd_arg.
REQ-016 busy SHALL equal (state==EXEC).
REQ-017 LOAD: EXEC SHALL last 1 cycle with counter load=1 and data_in=arg; count equals arg from the following cycle.
REQ-018 UP/DOWN: each EXEC cycle with remain!=0 SHALL drive enable=1 and up_down=1 for UP or 0 for DOWN, and decrement remain; EXEC ends after the cycle in which remain reaches 0.
REQ-019 PAUSE: EXEC SHALL hold enable=0 and load=0 for arg cycles.
REQ-020 arg=0 for UP/DOWN/PAUSE SHALL give 1 EXEC cycle with no count change.
REQ-021 EXEC duration SHALL be max(arg,1) cycles; done SHALL pulse in the first cycle back in IDLE.
REQ-022 A command offered in the done cycle SHALL be accepted in that cycle, giving back-to-back operation with one IDLE cycle between commands.
REQ-023 Outside EXEC, counter enable and load SHALL be 0, and count SHALL hold.
REQ-024 Counter arithmetic SHALL be modulo 16; wrap SHALL pulse in the cycle count shows the wrapped value.
REQ-025 abort while in EXEC SHALL return the FSM to IDLE at the next edge, suppress done, and stop counting; count keeps its value after the last enabled step.
REQ-026 abort in IDLE SHALL be ignored; abort with cmd_valid in IDLE SHALL still accept the command.

Reset
REQ-027 While rst is high at an edge: state=IDLE, remain=0, count=0, done=0, wrap=0, busy=0.
REQ-028 rst asserted mid-command SHALL discard the command without a done pulse.
REQ-029 The first acceptance SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-030 Opcode constants (OP_LOAD, OP_UP, OP_DOWN, OP_PAUSE) and state encodings SHALL live in a shared package/include (counter_ctrl_defs).
REQ-031 The block SHALL instantiate exactly one up_down_counter (clk, rst, enable, up_down, load, data_in, count), relying on its load-over-enable priority and synchronous reset to 0.
REQ-032 Sequencing logic (FSM, remain counter, pulse generation) SHALL be in counter_ctrl itself; no other sub-modules.

Verification
REQ-033 Reset, then LOAD 6 -> count=6 one cycle after EXEC; done pulses once; busy high for 1 cycle.
REQ-034 LOAD 14, then UP 3 back-to-back -> count 15, 0, 1; wrap pulses when count=0; done after the third step.
REQ-035 LOAD 1, then DOWN 2 -> count 0, 15; wrap pulses when count=15; final count=15.
REQ-036 PAUSE 4 with count=9 -> busy for 4 cycles, count stays 9; done after; UP 0 -> 1 EXEC cycle, count 9, done.
REQ-037 LOAD 0, UP 10, abort after 3 steps -> count=3, no done, cmd_ready=1 next cycle.
REQ-038 rst during DOWN 5 from 8 -> count=0, IDLE, no done; LOAD 5 is accepted in the first cycle after reset.

Source files
------------

// File: rtl/counter_ctrl_defs.sv
// Shared opcode constants and controller state encoding for counter_ctrl.
package counter_ctrl_defs;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_UP    = 2'b01;
   localparam logic [1:0] OP_DOWN  = 2'b10;
   localparam logic [1:0] OP_PAUSE = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_t;

endpackage

// File: rtl/up_down_counter.sv
// Modulo-2^WIDTH up/down counter; load has priority over enable, synchronous reset to 0.
module up_down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= data_in;
      end else if (enable) begin
         if (up_down) count <= count + 1'b1;
         else         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/counter_ctrl.sv
// Command sequencer driving one up_down_counter: LOAD, UP n, DOWN n, PAUSE n,
// with abort, one-cycle done pulse and wrap pulse.
module counter_ctrl
   import counter_ctrl_defs::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             wrap,
   output state_t           state_dbg
);

   // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
   // cmd_op/cmd_arg are captured at that edge. cmd_ready is high only in IDLE
   // and low whenever rst is high. The initiator may hold or drop cmd_valid freely.

   state_t           state_q, state_d;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] remain_q, remain_d;
   logic             done_q, wrap_q;
   logic             exec_last;
   logic             wrap_d;
   logic             cnt_enable, cnt_up_down, cnt_load;
   logic [WIDTH-1:0] cnt_data;
   logic             accept;

   assign cmd_ready = (state_q == ST_IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state_q == ST_EXEC);
   assign done      = done_q;
   assign wrap      = wrap_q;
   assign state_dbg = state_q;

   always_comb begin
      state_d     = state_q;
      remain_d    = remain_q;
      exec_last   = 1'b0;
      cnt_enable  = 1'b0;
      cnt_up_down = 1'b0;
      cnt_load    = 1'b0;
      cnt_data    = remain_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_d  = ST_EXEC;
               remain_d = cmd_arg;
            end
         end
         ST_EXEC: begin
            if (op_q == OP_LOAD) begin
               // For LOAD, remain carries the value to load.
               cnt_load  = !abort;
               exec_last = 1'b1;
               remain_d  = '0;
            end else begin
               exec_last   = (remain_q <= WIDTH'(1));
               cnt_up_down = (op_q == OP_UP);
               if (remain_q != '0) begin
                  remain_d   = remain_q - 1'b1;
                  cnt_enable = (op_q != OP_PAUSE) && !abort;
               end
            end
            if (abort || exec_last) begin
               state_d  = ST_IDLE;
               remain_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign wrap_d = cnt_enable && (cnt_up_down ? (count == '1) : (count == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         remain_q <= '0;
         op_q     <= OP_LOAD;
         done_q   <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         if (accept) op_q <= cmd_op;
         done_q   <= (state_q == ST_EXEC) && exec_last && !abort;
         wrap_q   <= wrap_d;
      end
   end

   up_down_counter #(.WIDTH(WIDTH)) u_counter (
      .clk     (clk),
      .rst     (rst),
      .enable  (cnt_enable),
      .up_down (cnt_up_down),
      .load    (cnt_load),
      .data_in (cnt_data),
      .count   (count)
   );

endmodule
